pipeline_ctrl: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage RV32I pipeline (F/D/E/M/W).

---
 rtl/rv32i_pkg.sv | 41 ++++
 rtl/hazard_fwd_unit.sv | 36 +++
 rtl/pipeline_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// +------------------------------------------------------------------+
// | rv32i_pkg : shared types and constants for the pipeline control   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package rv32i_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // x0 is hard-wired zero, so a write to it never produces a forwardable value
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs != 5'd0) begin
            if (wr_m && (rd_m == rs)) begin
                sel = FWD_M;
            end else if (wr_w && (rd_w == rs)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// +------------------------------------------------------------------+
// | hazard_fwd_unit : combinational load-use detect and E forwarding  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module hazard_fwd_unit
    import rv32i_pkg::*;
(
    input  logic [4:0] rs1D,
    input  logic [4:0] rs2D,
    input  logic [4:0] rs1E,
    input  logic [4:0] rs2E,
    input  logic [4:0] rdE,
    input  logic [2:0] mem_loadE,
    input  logic       reg_writeE,
    input  logic [4:0] rdM,
    input  logic       reg_writeM,
    input  logic [4:0] rdW,
    input  logic       reg_writeW,
    output logic       load_use,
    output logic [1:0] fwd_aE,
    output logic [1:0] fwd_bE
);

    logic load_in_e;

    assign load_in_e = (mem_loadE != 3'd0) && reg_writeE && (rdE != 5'd0);
    assign load_use  = load_in_e && ((rdE == rs1D) || (rdE == rs2D));

    assign fwd_aE = fwd_sel(rs1E, rdM, reg_writeM, rdW, reg_writeW);
    assign fwd_bE = fwd_sel(rs2E, rdM, reg_writeM, rdW, reg_writeW);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// +------------------------------------------------------------------+
// | pipeline_ctrl : hazard, memory-wait and flush control for 5-stage |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module pipeline_ctrl
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             NRST,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [2:0]       mem_loadE,
    input  logic             reg_writeE,
    input  logic [4:0]       rdM,
    input  logic             reg_writeM,
    input  logic [2:0]       mem_loadM,
    input  logic [1:0]       mem_storeM,
    input  logic [4:0]       rdW,
    input  logic             reg_writeW,
    input  logic             branch_takenE,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             en_pc,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_mw,
    output logic [1:0]       fwd_aE,
    output logic [1:0]       fwd_bE,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int              WC_W      = $clog2(TIMEOUT);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    ctrl_state_t     state;
    ctrl_state_t     state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_cnt_nxt;
    logic            err_set;
    logic            load_use;
    logic            memop;

    hazard_fwd_unit u_hazard_fwd (
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .rs1E       (rs1E),
        .rs2E       (rs2E),
        .rdE        (rdE),
        .mem_loadE  (mem_loadE),
        .reg_writeE (reg_writeE),
        .rdM        (rdM),
        .reg_writeM (reg_writeM),
        .rdW        (rdW),
        .reg_writeW (reg_writeW),
        .load_use   (load_use),
        .fwd_aE     (fwd_aE),
        .fwd_bE     (fwd_bE)
    );

    assign memop = (mem_loadM != 3'd0) || (mem_storeM != 2'd0);

    // Gated by NRST so the request drops the instant reset asserts
    assign dmem_req = NRST && memop && (state != ERROR);

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_set      = 1'b0;
        en_pc        = 1'b1;
        en_fd        = 1'b1;
        en_de        = 1'b1;
        en_em        = 1'b1;
        flush_fd     = 1'b0;
        flush_de     = 1'b0;
        flush_mw     = 1'b0;

        case (state)
            RUN: begin
                if (memop && !dmem_ready) begin
                    {en_pc, en_fd, en_de, en_em} = 4'b0000;
                    flush_mw     = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = '0;
                end else if (branch_takenE) begin
                    flush_fd = 1'b1;
                    flush_de = 1'b1;
                end else if (load_use) begin
                    en_pc    = 1'b0;
                    en_fd    = 1'b0;
                    flush_de = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    // Release cycle: a branch frozen in E takes effect now
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                    flush_fd     = branch_takenE;
                    flush_de     = branch_takenE;
                end else begin
                    {en_pc, en_fd, en_de, en_em} = 4'b0000;
                    flush_mw = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ERROR;
                        err_set   = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WC_W'(1);
                    end
                end
            end
            ERROR: begin
                {en_pc, en_fd, en_de, en_em} = 4'b0000;
                flush_mw = 1'b1;
            end
            default: begin
                {en_pc, en_fd, en_de, en_em} = 4'b0000;
                flush_mw  = 1'b1;
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            bus_err <= 1'b0;
        end else if (err_set) begin
            bus_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            stall_cnt <= '0;
        end else if (!en_pc && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// +------------------------------------------------------------------+
// | tb_pipeline_ctrl : directed + random check against a cycle model  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             NRST = 1'b0;
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [2:0]       mem_loadE, mem_loadM;
    logic [1:0]       mem_storeM;
    logic             reg_writeE, reg_writeM, reg_writeW, branch_takenE, dmem_ready;
    logic             dmem_req, en_pc, en_fd, en_de, en_em, flush_fd, flush_de, flush_mw, bus_err;
    logic [1:0]       fwd_aE, fwd_bE;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    // Model: outstanding = cycles the current M access has gone unanswered (0 = none)
    int m_out, m_stall, n_out, n_stall;
    bit m_err, m_bus, n_err, n_bus;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .NRST(NRST),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .mem_loadE(mem_loadE), .reg_writeE(reg_writeE),
        .rdM(rdM), .reg_writeM(reg_writeM), .mem_loadM(mem_loadM), .mem_storeM(mem_storeM),
        .rdW(rdW), .reg_writeW(reg_writeW), .branch_takenE(branch_takenE),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de), .en_em(en_em),
        .flush_fd(flush_fd), .flush_de(flush_de), .flush_mw(flush_mw),
        .fwd_aE(fwd_aE), .fwd_bE(fwd_bE), .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {mem_loadE, mem_loadM, mem_storeM}      = '0;
        {reg_writeE, reg_writeM, reg_writeW}    = '0;
        branch_takenE = 1'b0;
        dmem_ready    = 1'b0;
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (reg_writeM && rdM == rs) return 2'b10;
        if (reg_writeW && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Called at posedge+1 with inputs applied; leaves time at the falling edge
    task automatic eval();
        bit memop, lu, freeze, e_pc, e_fd, e_de, e_em, f_fd, f_de, f_mw;
        #4;
        memop = (mem_loadM != 0) || (mem_storeM != 0);
        lu = (mem_loadE != 0) && reg_writeE && (rdE != 0) && (rdE == rs1D || rdE == rs2D);
        {e_pc, e_fd, e_de, e_em} = 4'b1111;
        {f_fd, f_de, f_mw} = 3'b000;
        freeze = 0;
        n_out = m_out; n_err = m_err; n_bus = m_bus;
        if (m_err) begin
            freeze = 1;
        end else if (m_out > 0) begin
            if (dmem_ready) begin
                n_out = 0;
                f_fd  = branch_takenE;
                f_de  = branch_takenE;
            end else begin
                freeze = 1;
                if (m_out == TIMEOUT) begin
                    n_err = 1; n_bus = 1;
                end else begin
                    n_out = m_out + 1;
                end
            end
        end else if (memop && !dmem_ready) begin
            freeze = 1;
            n_out  = 1;
        end else if (branch_takenE) begin
            f_fd = 1; f_de = 1;
        end else if (lu) begin
            e_pc = 0; e_fd = 0; f_de = 1;
        end
        if (freeze) begin
            {e_pc, e_fd, e_de, e_em} = 4'b0000;
            f_mw = 1;
        end
        n_stall = (!e_pc && m_stall < SAT) ? m_stall + 1 : m_stall;
        chk("ctrl{req,pc,fd,de,em,ffd,fde,fmw}",
            {24'd0, dmem_req, en_pc, en_fd, en_de, en_em, flush_fd, flush_de, flush_mw},
            {24'd0, memop && !m_err, e_pc, e_fd, e_de, e_em, f_fd, f_de, f_mw});
        chk("fwd_aE", {30'd0, fwd_aE}, {30'd0, exp_fwd(rs1E)});
        chk("fwd_bE", {30'd0, fwd_bE}, {30'd0, exp_fwd(rs2E)});
        chk("bus_err", {31'd0, bus_err}, {31'd0, m_bus});
        chk("stall_cnt", {24'd0, stall_cnt}, m_stall);
    endtask

    task automatic adv();
        @(posedge CLK);
        m_out = n_out; m_err = n_err; m_bus = n_bus; m_stall = n_stall;
        #1;
    endtask

    // Called at posedge+1; returns at the next posedge+1 with reset released
    task automatic do_reset();
        NRST = 1'b0;
        #1;
        chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst stall_cnt", {24'd0, stall_cnt}, 32'd0);
        m_out = 0; m_err = 0; m_bus = 0; m_stall = 0;
        @(posedge CLK);
        #1;
        NRST = 1'b1;
    endtask

    task automatic randomize_inputs();
        rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
        rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
        rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
        rdW  = 5'($urandom_range(0, 3));
        mem_loadE  = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 5)) : 3'd0;
        reg_writeE = 1'($urandom); reg_writeM = 1'($urandom); reg_writeW = 1'($urandom);
        branch_takenE = ($urandom_range(0, 6) == 0);
        dmem_ready    = 1'($urandom);
        // The frozen M access stays presented while it is outstanding
        if (!(m_out > 0 && !m_err)) begin
            mem_loadM  = 3'd0;
            mem_storeM = 2'd0;
            case ($urandom_range(0, 7))
                0: mem_loadM  = 3'($urandom_range(1, 5));
                1: mem_storeM = 2'($urandom_range(1, 3));
                default: ;
            endcase
        end
    endtask

    initial begin
        clear_inputs();
        m_out = 0; m_err = 0; m_bus = 0; m_stall = 0;
        @(posedge CLK); #1;
        do_reset();

        // load-use bubble
        mem_loadE = 3'd2; reg_writeE = 1'b1; rdE = 5'd5; rs1D = 5'd5;
        eval();
        chk("lu en_pc", {31'd0, en_pc}, 32'd0);
        chk("lu en_fd", {31'd0, en_fd}, 32'd0);
        chk("lu flush_de", {31'd0, flush_de}, 32'd1);
        chk("lu en_em", {31'd0, en_em}, 32'd1);
        adv();
        clear_inputs();
        eval();
        chk("lu stall_cnt", {24'd0, stall_cnt}, 32'd1);
        chk("lu resolved en_pc", {31'd0, en_pc}, 32'd1);

        // forwarding priority and x0
        rdM = 5'd3; reg_writeM = 1'b1; rdW = 5'd3; reg_writeW = 1'b1; rs1E = 5'd3;
        rs2E = 5'd0;
        eval();
        chk("fwd M wins", {30'd0, fwd_aE}, 32'd2);
        chk("fwd x0 b", {30'd0, fwd_bE}, 32'd0);
        adv();
        rdM = 5'd0; rs1E = 5'd0; rdW = 5'd7; rs2E = 5'd7;
        eval();
        chk("fwd x0 a", {30'd0, fwd_aE}, 32'd0);
        chk("fwd W", {30'd0, fwd_bE}, 32'd1);
        adv();
        clear_inputs();

        // memory wait of 3 cycles then release
        do_reset();
        mem_loadM = 3'd2;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("wait en_pc", {31'd0, en_pc}, 32'd0);
            chk("wait flush_mw", {31'd0, flush_mw}, 32'd1);
            chk("wait dmem_req", {31'd0, dmem_req}, 32'd1);
            adv();
        end
        dmem_ready = 1'b1;
        eval();
        chk("release en_pc", {31'd0, en_pc}, 32'd1);
        chk("release en_em", {31'd0, en_em}, 32'd1);
        adv();
        clear_inputs();
        eval();
        chk("wait stall_cnt", {24'd0, stall_cnt}, 32'd3);
        chk("after release en_pc", {31'd0, en_pc}, 32'd1);
        adv();

        // branch overrides load-use
        mem_loadE = 3'd2; reg_writeE = 1'b1; rdE = 5'd5; rs2D = 5'd5; branch_takenE = 1'b1;
        eval();
        chk("br flush_fd", {31'd0, flush_fd}, 32'd1);
        chk("br flush_de", {31'd0, flush_de}, 32'd1);
        chk("br en_pc", {31'd0, en_pc}, 32'd1);
        adv();
        clear_inputs();

        // reset in the middle of a memory wait
        mem_storeM = 2'd1;
        eval(); adv();
        eval(); adv();
        do_reset();
        clear_inputs();
        eval();
        chk("post-rst en_pc", {31'd0, en_pc}, 32'd1);
        adv();

        // timeout into ERROR, then stall counter saturation
        mem_loadM = 3'd4;
        for (int i = 0; i < 17; i++) begin
            eval();
            if (i == 16) chk("pre-err bus_err", {31'd0, bus_err}, 32'd0);
            adv();
        end
        eval();
        chk("err bus_err", {31'd0, bus_err}, 32'd1);
        chk("err dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("err en_pc", {31'd0, en_pc}, 32'd0);
        adv();
        for (int i = 0; i < 260; i++) begin
            dmem_ready = 1'($urandom);
            eval();
            adv();
        end
        eval();
        chk("sat stall_cnt", {24'd0, stall_cnt}, 32'hFF);
        adv();
        clear_inputs();
        do_reset();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            eval();
            adv();
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
